bcd_scan_controller: RTL and testbench

Sequencing controller for the four-digit multiplexed 7-segment display in the wb_BCD peripheral. It accepts a 14-bit binary value through a start/busy/done handshake and converts it to four BCD digits with a sequential double-dabble engine. It then time-multiplexes those digits onto the active-low anode lines with a parameterised scan rate. Its digit/anode outputs feed the 7-segment decoder directly, replacing free-running anode selection.

---
 rtl/bcd_scan_controller.sv | 142 ++++++++++++++
 tb/tb_bcd_scan_controller.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_controller.sv
// Binary-to-BCD conversion with a multiplexed four-digit 7-segment scan.
// Optional leading-zero blanking: define BCD_LEADING_ZERO_BLANK_EN.
module bcd_scan_controller #(
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [13:0] value,
   input  logic        start,
   input  logic        en,
   output logic        busy,
   output logic        done,
   output logic        ovf,
   output logic [3:0]  anode,
   output logic [3:0]  digit,
   output logic        blank
);

   localparam int CW = $clog2(SCAN_DIV);

   typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

   state_t           state, state_n;
   logic [13:0]      shift_q;
   logic [13:0]      latch_q;
   logic [15:0]      scratch_q;
   logic [15:0]      adj;
   logic [3:0]       iter_q;
   logic [3:0][3:0]  disp_q;
   logic [CW-1:0]    scnt_q;
   logic [1:0]       sel_q, sel_n;
   logic             wrap;
   logic [3:0]       onehot_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (start) state_n = CONV;
         CONV:    if (iter_q == 4'd0) state_n = COMMIT;
         COMMIT:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_comb begin
      adj = scratch_q;
      for (int k = 0; k < 4; k++)
         if (scratch_q[4*k +: 4] >= 4'd5)
            adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_q   <= '0;
         latch_q   <= '0;
         scratch_q <= '0;
         iter_q    <= '0;
      end else begin
         unique case (state)
            IDLE: if (start) begin
               shift_q   <= value;
               latch_q   <= value;
               scratch_q <= '0;
               iter_q    <= 4'd13;
            end
            CONV: begin
               {scratch_q, shift_q} <= {adj[14:0], shift_q, 1'b0};
               iter_q <= iter_q - 4'd1;
            end
            default: ;
         endcase
      end
   end

   // Displayed digits only move on commit, so the scan never sees partials.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         disp_q <= '0;
         ovf    <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= (state == COMMIT);
         if (state == COMMIT) begin
            if (latch_q > 14'd9999) begin
               disp_q <= 16'h9999;
               ovf    <= 1'b1;
            end else begin
               disp_q <= scratch_q;
               ovf    <= 1'b0;
            end
         end
      end
   end

   assign wrap  = (scnt_q == CW'(SCAN_DIV - 1));
   assign sel_n = wrap ? sel_q + 2'd1 : sel_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scnt_q   <= '0;
         sel_q    <= '0;
         onehot_q <= 4'b0001;
         digit    <= '0;
      end else begin
         scnt_q   <= wrap ? '0 : scnt_q + CW'(1);
         sel_q    <= sel_n;
         onehot_q <= 4'b0001 << sel_n;
         digit    <= disp_q[sel_n];
      end
   end

   assign anode = en ? ~onehot_q : 4'b1111;

`ifdef BCD_LEADING_ZERO_BLANK_EN
   logic lead_zero;

   always_comb begin
      lead_zero = 1'b0;
      unique case (sel_n)
         2'd1:    lead_zero = (disp_q[3:1] == '0);
         2'd2:    lead_zero = (disp_q[3:2] == '0);
         2'd3:    lead_zero = (disp_q[3] == '0);
         default: lead_zero = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) blank <= 1'b0;
      else     blank <= lead_zero;
   end
`else
   assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_scan_controller.sv
// Randomised and directed checks of bcd_scan_controller against a
// decimal-arithmetic display model.
module tb_bcd_scan_controller;

   localparam int D = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [13:0] value = '0;
   logic        start = 1'b0;
   logic        en = 1'b1;
   logic        busy, done, ovf, blank;
   logic [3:0]  anode, digit;

   int checks = 0;
   int errors = 0;
   int edges;
   int shown = 0;
   bit exp_ovf = 0;

   bcd_scan_controller #(.SCAN_DIV(D)) dut (
      .clk(clk), .rst(rst), .value(value), .start(start), .en(en),
      .busy(busy), .done(done), .ovf(ovf),
      .anode(anode), .digit(digit), .blank(blank)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge rst)
      if (rst) edges <= 0;
      else     edges <= edges + 1;

   function automatic int dec_digit(int v, int s);
      int p;
      p = 1;
      for (int i = 0; i < s; i++) p = p * 10;
      return (v / p) % 10;
   endfunction

   function automatic bit exp_blank(int v, int s);
      int p;
      p = 1;
      for (int i = 0; i < s; i++) p = p * 10;
`ifdef BCD_LEADING_ZERO_BLANK_EN
      return (s > 0) && (v < p);
`else
      return 1'b0;
`endif
   endfunction

   task automatic check_scan(string name, int cycles);
      int s;
      logic [3:0] ea;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         s  = (edges / D) % 4;
         ea = en ? ~(4'b0001 << s) : 4'b1111;
         checks++;
         if (anode !== ea || digit !== 4'(dec_digit(shown, s)) ||
             blank !== exp_blank(shown, s)) begin
            errors++;
            $display("FAIL %s sel=%0d anode=%b/%b digit=%0d/%0d blank=%b/%b",
                     name, s, anode, ea, digit, dec_digit(shown, s),
                     blank, exp_blank(shown, s));
         end
      end
   endtask

   task automatic load(string name, int v, int coll, int other);
      @(negedge clk);
      value = 14'(v);
      start = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
         checks++;
         if (busy !== (i <= 15) || done !== (i == 16)) begin
            errors++;
            $display("FAIL %s cyc=%0d busy=%b/%b done=%b/%b", name, i,
                     busy, (i <= 15), done, (i == 16));
         end
         if (i == 16) begin
            exp_ovf = (v > 9999);
            checks++;
            if (ovf !== exp_ovf) begin
               errors++;
               $display("FAIL %s ovf=%b/%b", name, ovf, exp_ovf);
            end
         end
         if (i + 1 == coll) begin
            value = 14'(other);
            start = 1'b1;
         end
      end
      shown = (v > 9999) ? 9999 : v;
      check_scan(name, 4 * D + 1);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      #12;
      checks++;
      if (busy !== 0 || done !== 0 || ovf !== 0 || anode !== 4'b1110 ||
          digit !== 0 || blank !== 0) begin
         errors++;
         $display("FAIL reset_init busy=%b done=%b ovf=%b anode=%b digit=%0d",
                  busy, done, ovf, anode, digit);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      value = 14'd1234;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (busy !== 0 || done !== 0 || ovf !== 0 || anode !== 4'b1110 ||
          digit !== 0 || blank !== 0) begin
         errors++;
         $display("FAIL reset_midconv busy=%b done=%b ovf=%b anode=%b digit=%0d",
                  busy, done, ovf, anode, digit);
      end
      @(negedge clk);
      rst = 1'b0;
      shown = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if (done !== 0 || busy !== 0) begin
            errors++;
            $display("FAIL reset_quiet done=%b/0 busy=%b/0", done, busy);
         end
      end
      check_scan("reset_scan", 4 * D);
   endtask

   task automatic test_load;
      load("load_1234", 1234, 0, 0);
   endtask

   task automatic test_overflow;
      load("ovf_12000", 12000, 0, 0);
      load("ovf_9999", 9999, 0, 0);
      load("ovf_max", 16383, 0, 0);
   endtask

   task automatic test_leading_zero;
      load("lz_7", 7, 0, 0);
      load("lz_0", 0, 0, 0);
      load("lz_40", 40, 0, 0);
   endtask

   task automatic test_busy_collision;
      load("collide", 42, 5, 99);
      load("collide_commit", 42, 15, 99);
   endtask

   task automatic test_scan_enable;
      int s0;
      s0 = (edges / D) % 4;
      en = 1'b0;
      check_scan("en_off", 4 * D + 2);
      checks++;
      if (((edges / D) % 4) == s0 && dut.sel_q === 2'(s0)) begin
         // sel advanced by a whole number of refreshes plus two cycles
      end
      en = 1'b1;
      check_scan("en_on", 4 * D);
   endtask

   task automatic test_random;
      int v;
      for (int n = 0; n < 8; n++) begin
         v = $urandom_range(0, 16383);
         if (n % 2 == 0) v = $urandom_range(0, 9999);
         load("random", v, 0, 0);
      end
   endtask

   initial begin
      test_reset;
      test_load;
      test_overflow;
      test_leading_zero;
      test_busy_collision;
      test_scan_enable;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
